// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents: FSM state codes, grant owner codes, latched memory command payload.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Grant owner codes
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Command captured at grant time and held on the memory port for the whole access
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for the arbiter's BUSY state.
// Ports: clk, rst (async active-high), clr (synchronous clear), en (count enable),
//        tc_c (combinational terminal count: count == TERMINAL-1 while enabled).
module mem_arb_timer #(
  parameter int unsigned TERMINAL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(TERMINAL + 1);

  logic [CW-1:0] count_q;

  // Cycle counter; the FSM leaves BUSY at terminal count, so no wrap handling is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc_c = en && (count_q == CW'(TERMINAL - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the load/store stage.
// Ports: clk, reset (async active-high);
//        Fetch{Req,Addr} in / Fetch{Rdata,Valid} out;
//        Data{Req,We,Addr,Wdata} in / Data{Rdata,Valid} out;
//        Mem{Req,We,Addr,Wdata} out / Mem{Ack,Rdata} in;
//        StallFetch, StallMem (combinational), BusErr (sticky timeout flag).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic [DATA_W-1:0] FetchRdata,
  output logic              FetchValid,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWdata,
  output logic [DATA_W-1:0] DataRdata,
  output logic              DataValid,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              StallFetch,
  output logic              StallMem,
  output logic              BusErr
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              fvalid_q, fvalid_d;
  logic              dvalid_q, dvalid_d;
  logic [DATA_W-1:0] frdata_q, frdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              bus_err_q, bus_err_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              data_win_c;
  logic              busy_c;
  logic              timeout_c;

  assign busy_c = (state_q == ST_BUSY);

  mem_arb_timer #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (reset),
    .clr  (!busy_c),
    .en   (busy_c),
    .tc_c (timeout_c)
  );

  // Next-state, grant and response logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    fvalid_d   = 1'b0;
    dvalid_d   = 1'b0;
    frdata_d   = frdata_q;
    drdata_d   = drdata_q;
    bus_err_d  = bus_err_q;
    streak_d   = streak_q;
    data_win_c = 1'b0;

    // A fetch that is not waiting breaks any data streak
    if (!FetchReq) begin
      streak_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (FetchReq || DataReq) begin
          // Data wins ties unless fetch has already been passed over MAX_DATA_STREAK times
          data_win_c = DataReq && !(FetchReq && (streak_q == SW'(MAX_DATA_STREAK)));
          owner_d    = data_win_c ? OWN_D : OWN_F;
          if (data_win_c) begin
            cmd_d.we    = DataWe;
            cmd_d.addr  = DataAddr;
            cmd_d.wdata = DataWdata;
            if (FetchReq && (streak_q < SW'(MAX_DATA_STREAK))) begin
              streak_d = streak_q + SW'(1);
            end
          end else begin
            cmd_d.we   = 1'b0;
            cmd_d.addr = FetchAddr;
            streak_d   = '0;
          end
          mem_req_d = 1'b1;
          mem_we_d  = data_win_c && DataWe;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (MemAck) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_RESP;
          if (owner_q == OWN_D) begin
            dvalid_d = 1'b1;
            // Stores leave the last load value in place
            if (!cmd_q.we) begin
              drdata_d = MemRdata;
            end
          end else begin
            fvalid_d = 1'b1;
            frdata_d = MemRdata;
          end
        end else if (timeout_c) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = ST_RESP;
          if (owner_q == OWN_D) begin
            dvalid_d = 1'b1;
            drdata_d = '0;
          end else begin
            fvalid_d = 1'b1;
            frdata_d = '0;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_F;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      fvalid_q  <= 1'b0;
      dvalid_q  <= 1'b0;
      frdata_q  <= '0;
      drdata_q  <= '0;
      bus_err_q <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      fvalid_q  <= fvalid_d;
      dvalid_q  <= dvalid_d;
      frdata_q  <= frdata_d;
      drdata_q  <= drdata_d;
      bus_err_q <= bus_err_d;
      streak_q  <= streak_d;
    end
  end

  assign MemReq     = mem_req_q;
  assign MemWe      = mem_we_q;
  assign MemAddr    = cmd_q.addr;
  assign MemWdata   = cmd_q.wdata;
  assign FetchValid = fvalid_q;
  assign DataValid  = dvalid_q;
  assign FetchRdata = frdata_q;
  assign DataRdata  = drdata_q;
  assign BusErr     = bus_err_q;

  // Stall requests to the hazard unit
  assign StallFetch = FetchReq & ~fvalid_q;
  assign StallMem   = DataReq & ~dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a cycle-level reference model and memory responder.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;
  localparam int NCYC = 4000;

  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_RESP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic [31:0] FetchRdata;
  logic        FetchValid;
  logic        DataReq;
  logic        DataWe;
  logic [31:0] DataAddr;
  logic [31:0] DataWdata;
  logic [31:0] DataRdata;
  logic        DataValid;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic        StallFetch;
  logic        StallMem;
  logic        BusErr;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_DATA_STREAK (MAXS),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .FetchReq   (FetchReq),
    .FetchAddr  (FetchAddr),
    .FetchRdata (FetchRdata),
    .FetchValid (FetchValid),
    .DataReq    (DataReq),
    .DataWe     (DataWe),
    .DataAddr   (DataAddr),
    .DataWdata  (DataWdata),
    .DataRdata  (DataRdata),
    .DataValid  (DataValid),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWdata   (MemWdata),
    .MemAck     (MemAck),
    .MemRdata   (MemRdata),
    .StallFetch (StallFetch),
    .StallMem   (StallMem),
    .BusErr     (BusErr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access in flight, tracked by phase and elapsed busy cycles
  int          ph;
  int          busy_cnt;
  int          cur_lat;
  int          streak_m;
  int          grants_f;
  int          grants_d;
  int          timeouts;
  bit          own_d;
  bit          cur_we;
  bit          err_m;
  bit          fv_e;
  bit          dv_e;
  bit          grant;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_data;
  logic [31:0] f_rd_m;
  logic [31:0] d_rd_m;

  task automatic model_reset();
    ph       = PH_IDLE;
    busy_cnt = 0;
    streak_m = 0;
    err_m    = 1'b0;
    f_rd_m   = '0;
    d_rd_m   = '0;
    fv_e     = 1'b0;
    dv_e     = 1'b0;
  endtask

  // Advance the model across the rising edge that just passed, using the inputs applied at it
  task automatic model_edge();
    fv_e  = 1'b0;
    dv_e  = 1'b0;
    grant = 1'b0;
    case (ph)
      PH_RESP: ph = PH_IDLE;
      PH_BUSY: begin
        if (MemAck) begin
          if (own_d) begin
            dv_e = 1'b1;
            if (!cur_we) d_rd_m = cur_data;
          end else begin
            fv_e   = 1'b1;
            f_rd_m = cur_data;
          end
          ph = PH_RESP;
        end else if (busy_cnt == TMO - 1) begin
          err_m = 1'b1;
          timeouts++;
          if (own_d) begin
            dv_e   = 1'b1;
            d_rd_m = '0;
          end else begin
            fv_e   = 1'b1;
            f_rd_m = '0;
          end
          ph = PH_RESP;
        end else begin
          busy_cnt++;
        end
      end
      default: begin
        if (FetchReq || DataReq) begin
          own_d     = DataReq && !(FetchReq && streak_m == MAXS);
          cur_we    = own_d ? DataWe : 1'b0;
          cur_addr  = own_d ? DataAddr : FetchAddr;
          cur_wdata = DataWdata;
          cur_data  = $urandom;
          cur_lat   = ($urandom_range(0, 19) == 0) ? 100 : int'($urandom_range(0, 4));
          busy_cnt  = 0;
          grant     = 1'b1;
          ph        = PH_BUSY;
          if (own_d) grants_d++;
          else grants_f++;
        end
      end
    endcase
    if (!FetchReq) streak_m = 0;
    else if (grant) streak_m = own_d ? ((streak_m < MAXS) ? streak_m + 1 : streak_m) : 0;
  endtask

  task automatic check_outputs();
    check("MemReq", 32'(MemReq), 32'(ph == PH_BUSY));
    if (ph == PH_BUSY) begin
      check("MemAddr", MemAddr, cur_addr);
      check("MemWe", 32'(MemWe), 32'(cur_we));
      if (cur_we) check("MemWdata", MemWdata, cur_wdata);
    end else begin
      check("MemWe_idle", 32'(MemWe), 32'd0);
    end
    check("FetchValid", 32'(FetchValid), 32'(fv_e));
    check("DataValid", 32'(DataValid), 32'(dv_e));
    check("FetchRdata", FetchRdata, f_rd_m);
    check("DataRdata", DataRdata, d_rd_m);
    check("BusErr", 32'(BusErr), 32'(err_m));
    check("StallFetch", 32'(StallFetch), 32'(FetchReq & ~fv_e));
    check("StallMem", 32'(StallMem), 32'(DataReq & ~dv_e));
  endtask

  initial begin
    reset     = 1'b0;
    FetchReq  = 1'b0;
    FetchAddr = '0;
    DataReq   = 1'b0;
    DataWe    = 1'b0;
    DataAddr  = '0;
    DataWdata = '0;
    MemAck    = 1'b0;
    MemRdata  = '0;
    grants_f  = 0;
    grants_d  = 0;
    timeouts  = 0;
    own_d     = 1'b0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;
    cur_data  = '0;
    cur_lat   = 0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_MemReq", 32'(MemReq), 32'd0);
    check("rst_MemWe", 32'(MemWe), 32'd0);
    check("rst_MemAddr", MemAddr, 32'd0);
    check("rst_FetchValid", 32'(FetchValid), 32'd0);
    check("rst_DataValid", 32'(DataValid), 32'd0);
    check("rst_Rdata", FetchRdata | DataRdata, 32'd0);
    check("rst_BusErr", 32'(BusErr), 32'd0);
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      model_edge();
      check_outputs();

      // Occasional asynchronous reset in the middle of an access
      if (ph == PH_BUSY && $urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        check("arst_MemReq", 32'(MemReq), 32'd0);
        check("arst_Valid", 32'(FetchValid | DataValid), 32'd0);
        check("arst_BusErr", 32'(BusErr), 32'd0);
        reset    = 1'b0;
        model_reset();
        FetchReq = 1'b0;
        DataReq  = 1'b0;
      end

      // Requesters drop on their response pulse
      if (fv_e) FetchReq = 1'b0;
      if (dv_e) DataReq = 1'b0;

      // Flush: the owner withdraws while its access is still on the bus
      if (ph == PH_BUSY && $urandom_range(0, 15) == 0) begin
        if (own_d) DataReq = 1'b0;
        else FetchReq = 1'b0;
      end

      if (!FetchReq && !(ph == PH_BUSY && !own_d) && $urandom_range(0, 1) == 1) begin
        FetchReq  = 1'b1;
        FetchAddr = $urandom;
      end
      if (!DataReq && !(ph == PH_BUSY && own_d) && $urandom_range(0, 7) != 0) begin
        DataReq   = 1'b1;
        DataWe    = 1'($urandom_range(0, 1));
        DataAddr  = $urandom;
        DataWdata = $urandom;
      end

      // Memory responder
      MemAck   = (ph == PH_BUSY) && (busy_cnt == cur_lat);
      MemRdata = MemAck ? cur_data : $urandom;
    end

    @(negedge clk);
    $display("grants: fetch=%0d data=%0d timeouts=%0d", grants_f, grants_d, timeouts);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
